// File: rtl/rng_pkg.sv
// Shared types and constants for the game RNG scheduler: FSM states and
// the 16-bit Galois LFSR definition.
package rng_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DELIVER
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/rng_scheduler_if.sv
// Requester-side bus of the RNG scheduler: level requests and bounds in,
// one-hot grant with the delivered number out.
interface rng_scheduler_if
  import rng_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int NUM_W = 4
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*NUM_W-1:0] bound;
  logic                   reseed;
  logic [LFSR_W-1:0]      seed_in;
  logic [N_REQ-1:0]       grant;
  logic [NUM_W-1:0]       num;
  logic                   valid;
  logic                   busy;

  modport master (output req, bound, reseed, seed_in,
                  input  grant, num, valid, busy);
  modport slave  (input  req, bound, reseed, seed_in,
                  output grant, num, valid, busy);
endinterface

// File: rtl/rng_scheduler_lfsr16.sv
// Free-running 16-bit Galois LFSR with a synchronous load; a zero load value
// is replaced by SEED so the register can never lock up at all-zero.
module lfsr16
  import rng_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              posclk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge posclk or negedge rst_n) begin
    if (!rst_n)    q <= SEED;
    else if (load) q <= (load_val == '0) ? SEED : load_val;
    else           q <= lfsr_step(q);
  end

endmodule

// File: rtl/rng_scheduler.sv
// Round-robin arbiter sharing one LFSR between N_REQ requesters; each grant
// draws a bounded value by rejection sampling with a capped retry count.
module rng_scheduler
  import rng_pkg::*;
#(
  parameter int                N_REQ   = 4,
  parameter int                NUM_W   = 4,
  parameter int                MAX_TRY = 8,
  parameter logic [LFSR_W-1:0] SEED    = DEFAULT_SEED
) (
  input logic             posclk,
  input logic             rst_n,
  rng_scheduler_if.slave  bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TRY_W = $clog2(MAX_TRY + 1);
  localparam int unsigned NREQ_U = N_REQ;
  localparam logic [N_REQ-1:0] GRANT_LSB = N_REQ'(1);

  state_t            state;
  logic [IDX_W-1:0]  sel, rr_last, pick, j_idx;
  logic              pick_any;
  logic [NUM_W-1:0]  bnd, pick_bnd, cand, draw_val, num_q;
  logic [NUM_W-1:0]  bnd_arr [N_REQ];
  logic [TRY_W-1:0]  try_cnt;
  logic              cand_ok, draw_done;
  logic [N_REQ-1:0]  grant_q;
  logic              valid_q, busy_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_unused;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .posclk   (posclk),
    .rst_n    (rst_n),
    .load     (bus.reseed),
    .load_val (bus.seed_in),
    .q        (lfsr_q)
  );

  assign cand        = lfsr_q[NUM_W-1:0];
  assign lfsr_unused = ^lfsr_q[LFSR_W-1:NUM_W];

  for (genvar g = 0; g < N_REQ; g++) begin : g_bnd
    assign bnd_arr[g] = bus.bound[g*NUM_W +: NUM_W];
  end

  // Search starts just past the last served requester so it ends up lowest priority.
  always_comb begin
    pick     = '0;
    pick_any = 1'b0;
    pick_bnd = '0;
    j_idx    = '0;
    for (int unsigned k = 1; k <= NREQ_U; k++) begin
      j_idx = IDX_W'((32'(rr_last) + k) % NREQ_U);
      if (!pick_any && bus.req[j_idx]) begin
        pick_any = 1'b1;
        pick     = j_idx;
        pick_bnd = bnd_arr[j_idx];
      end
    end
  end

  always_comb begin
    cand_ok   = (cand <= bnd);
    draw_done = cand_ok || (try_cnt == TRY_W'(MAX_TRY - 1));
    draw_val  = cand_ok ? cand : bnd;
  end

  // Outputs are registered on the edge entering DELIVER, so they coincide with that state.
  always_ff @(posedge posclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= '0;
      rr_last <= IDX_W'(N_REQ - 1);
      bnd     <= '0;
      try_cnt <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      grant_q <= '0;
      if (bus.reseed) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (pick_any) begin
              sel     <= pick;
              bnd     <= pick_bnd;
              try_cnt <= '0;
              state   <= DRAW;
              busy_q  <= 1'b1;
            end
          end
          DRAW: begin
            if (draw_done) begin
              num_q   <= draw_val;
              valid_q <= 1'b1;
              grant_q <= GRANT_LSB << sel;
              rr_last <= sel;
              state   <= DELIVER;
            end else begin
              try_cnt <= try_cnt + 1'b1;
            end
          end
          DELIVER: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.grant = grant_q;
  assign bus.num   = num_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_rng_scheduler.sv
// Scoreboard bench for rng_scheduler: stimulus pushes predicted deliveries,
// a negedge monitor pops and compares them against each valid strobe.
module tb_rng_scheduler;
  import rng_pkg::*;

  localparam int N_REQ   = 4;
  localparam int NUM_W   = 4;
  localparam int MAX_TRY = 8;

  logic posclk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 posclk = ~posclk;

  rng_scheduler_if #(.N_REQ(N_REQ), .NUM_W(NUM_W)) bus ();

  rng_scheduler #(
    .N_REQ   (N_REQ),
    .NUM_W   (NUM_W),
    .MAX_TRY (MAX_TRY),
    .SEED    (16'hACE1)
  ) dut (
    .posclk (posclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0] g;
    logic [3:0] n;
    logic [3:0] b;
    int         c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  logic [15:0] m;

  // Reference LFSR, written from the shift/tap description.
  function automatic logic [15:0] ref_next(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  always @(posedge posclk) cyc <= cyc + 1;

  always @(posedge posclk or negedge rst_n) begin
    if (!rst_n)           m <= 16'hACE1;
    else if (bus.reseed)  m <= (bus.seed_in == 16'h0) ? 16'hACE1 : bus.seed_in;
    else                  m <= ref_next(m);
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
  endtask

  // cur = LFSR value in the cycle before the sampling edge t_edge.
  function automatic exp_t predict(input int idx, input logic [3:0] b, input logic [15:0] cur,
                                   input int skip, input int t_edge);
    logic [15:0] s;
    exp_t e;
    s   = cur;
    for (int i = 0; i < skip; i++) s = ref_next(s);
    e.g = 4'b0001 << idx;
    e.b = b;
    e.n = b;
    e.c = t_edge + MAX_TRY;
    for (int i = 0; i < MAX_TRY; i++) begin
      s = ref_next(s);
      if (s[3:0] <= b) begin
        e.n = s[3:0];
        e.c = t_edge + 1 + i;
        break;
      end
    end
    return e;
  endfunction

  // Monitor
  logic prev_valid = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge posclk);
      if (rst_n) begin
        if (prev_valid) check("valid_width", {31'b0, bus.valid}, 32'd0);
        if (bus.valid) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_valid: got grant=%b num=%0d expected no delivery", bus.grant, bus.num);
          end else begin
            e = sb.pop_front();
            check("grant", {28'b0, bus.grant}, {28'b0, e.g});
            check("num", {28'b0, bus.num}, {28'b0, e.n});
            check("num_le_bound", {31'b0, bus.num <= e.b}, 32'd1);
            check("latency_cycle", cyc, e.c);
            check("busy_at_valid", {31'b0, bus.busy}, 32'd1);
          end
        end
        prev_valid = bus.valid;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!bus.valid && n < 2 + MAX_TRY + 2) begin
      @(negedge posclk);
      n++;
    end
    if (!bus.valid) begin
      checks++;
      $display("FAIL %s_timeout: got no valid after %0d cycles, expected within %0d", nm, n, 2 + MAX_TRY);
    end
  endtask

  task automatic issue(input int idx, input logic [3:0] b);
    bus.bound = {N_REQ{b}};
    sb.push_back(predict(idx, b, m, 0, cyc + 1));
    bus.req = 4'b0001 << idx;
  endtask

  task automatic serve(input int idx, input logic [3:0] b, input string nm);
    issue(idx, b);
    wait_valid(nm);
    bus.req = '0;
    @(negedge posclk);
  endtask

  task automatic do_reseed(input logic [15:0] s, input logic [15:0] exp_lfsr, input string nm);
    bus.seed_in = s;
    bus.reseed  = 1'b1;
    @(negedge posclk);
    bus.reseed  = 1'b0;
    check(nm, {16'b0, dut.u_lfsr.q}, {16'b0, exp_lfsr});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge posclk);
    rst_n = 1'b1;
    @(negedge posclk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected bench to end");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [15:0] cur;
    bus.req = '0; bus.bound = '0; bus.reseed = 1'b0; bus.seed_in = '0;
    repeat (2) @(negedge posclk);
    check("rst_num",   {28'b0, bus.num},   32'd0);
    check("rst_valid", {31'b0, bus.valid}, 32'd0);
    check("rst_grant", {28'b0, bus.grant}, 32'd0);
    check("rst_busy",  {31'b0, bus.busy},  32'd0);
    check("rst_lfsr",  {16'b0, dut.u_lfsr.q}, 32'h0000ACE1);
    rst_n = 1'b1;
    @(negedge posclk);

    // 1: single request, best-case latency, bound change after latch ignored
    issue(0, 4'd15);
    @(negedge posclk);
    check("t1_busy_draw",  {31'b0, bus.busy},  32'd1);
    check("t1_no_early_valid", {31'b0, bus.valid}, 32'd0);
    bus.bound = '0;
    wait_valid("t1");
    bus.req = '0;
    @(negedge posclk);
    check("t1_busy_idle", {31'b0, bus.busy}, 32'd0);

    // 2: all four held, round-robin one grant every 3 cycles
    do_reset();
    bus.bound = {N_REQ{4'd15}};
    t0  = cyc + 1;
    cur = m;
    for (int k = 0; k < 5; k++) sb.push_back(predict(k % 4, 4'd15, cur, 3 * k, t0 + 3 * k));
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_valid("t2");
      if (k == 4) bus.req = '0;
      @(negedge posclk);
    end
    @(negedge posclk);

    // 3: tight bound, many requests
    for (int k = 0; k < 200; k++) serve(k % 4, 4'd3, "t3");

    // 4: zero bound forces fallback path often
    for (int k = 0; k < 8; k++) serve(k % 4, 4'd0, "t4");

    // 5: deterministic replay after reseed, zero seed substitution
    do_reseed(16'h0001, 16'h0001, "t5_seed1");
    for (int k = 0; k < 10; k++) serve(k % 4, 4'd5, "t5a");
    do_reseed(16'h0001, 16'h0001, "t5_seed1_again");
    for (int k = 0; k < 10; k++) serve(k % 4, 4'd5, "t5b");
    do_reseed(16'h0000, 16'hACE1, "t5_seed0");

    // 6a: reseed mid-DRAW aborts; held request is re-served
    bus.bound = {N_REQ{4'd15}};
    bus.req   = 4'b0100;
    @(negedge posclk);
    do_reseed(16'h1234, 16'h1234, "t6_seed");
    check("t6_abort_valid", {31'b0, bus.valid}, 32'd0);
    check("t6_abort_grant", {28'b0, bus.grant}, 32'd0);
    check("t6_abort_busy",  {31'b0, bus.busy},  32'd0);
    sb.push_back(predict(2, 4'd15, m, 0, cyc + 1));
    wait_valid("t6_reserve");
    bus.req = '0;
    @(negedge posclk);

    // 6b: reseed and request together in IDLE; reseed wins
    bus.req = 4'b0001;
    do_reseed(16'h00FF, 16'h00FF, "t6b_seed");
    check("t6b_still_idle", {31'b0, bus.busy}, 32'd0);
    sb.push_back(predict(0, 4'd15, m, 0, cyc + 1));
    wait_valid("t6b");
    bus.req = '0;
    @(negedge posclk);

    // 6c: asynchronous reset mid-DRAW
    bus.req = 4'b0010;
    @(negedge posclk);
    rst_n = 1'b0;
    #1;
    check("t6c_num",   {28'b0, bus.num},   32'd0);
    check("t6c_valid", {31'b0, bus.valid}, 32'd0);
    check("t6c_grant", {28'b0, bus.grant}, 32'd0);
    check("t6c_busy",  {31'b0, bus.busy},  32'd0);
    bus.req = '0;
    @(negedge posclk);
    rst_n = 1'b1;
    repeat (5) @(negedge posclk);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
